// File: rtl/branch_pkg.sv
// Shared decode constants, branch kinds and the BHT counter update rule
// for the branch resolution unit.
package branch_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      KIND_OTHER  = 2'b00,
      KIND_BRANCH = 2'b01,
      KIND_JAL    = 2'b10,
      KIND_JALR   = 2'b11
   } br_kind_e;

   // Two-bit saturating counter step: 11 is strongly taken, 00 strongly not-taken.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         if (cnt == 2'b11) nxt = cnt;
         else              nxt = cnt + 2'b01;
      end else begin
         if (cnt == 2'b00) nxt = cnt;
         else              nxt = cnt - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Resolution bundle between decode/register-read (master) and the branch
// unit (slave): instruction operands in, resolved control-flow result out.
interface branch_unit_if
   import branch_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic [6:0]      in_opcode;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_imm;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            in_pred_taken;
   logic [XLEN-1:0] in_pred_target;

   logic            out_valid;
   logic            br_en;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] link_data;
   logic            misalign;
   logic            illegal;

   modport master (
      output in_valid, in_opcode, in_funct3, in_pc, in_imm, rs1_data, rs2_data,
             in_pred_taken, in_pred_target,
      input  out_valid, br_en, redirect, redirect_pc, link_data, misalign, illegal
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_pc, in_imm, rs1_data, rs2_data,
             in_pred_taken, in_pred_target,
      output out_valid, br_en, redirect, redirect_pc, link_data, misalign, illegal
   );

endinterface

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with a
// combinational read port for fetch and a clocked training port.
module branch_bht
   import branch_pkg::*;
#(
   parameter int         IDX_W = 6,
   parameter logic [1:0] INIT  = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0] cnt_r [DEPTH];

   // Counter storage: reset loads every entry, training steps one entry per edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            cnt_r[i] <= INIT;
         end
      end else if (wr_en) begin
         cnt_r[wr_idx] <= sat_update(cnt_r[wr_idx], wr_taken);
      end else begin
         cnt_r[wr_idx] <= cnt_r[wr_idx];
      end
   end

   // A same-index write lands at the edge, so the read still shows the old counter.
   assign rd_taken = cnt_r[rd_idx][1];

endmodule

// File: rtl/branch_unit.sv
// Single-stage branch/jump resolution: compare, target, mispredict redirect,
// link value, and training of the branch history table.
module branch_unit
   import branch_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         BHT_IDX_W = 6,
   parameter logic [1:0] BHT_INIT  = 2'b01
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   branch_unit_if.slave    bus
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

   br_kind_e        kind_s;
   logic            accept_s;
   logic            cond_s;
   logic            legal_f3_s;
   logic            taken_s;
   logic            illegal_s;
   logic            misalign_s;
   logic            redirect_s;
   logic [XLEN-1:0] pc_plus4_s;
   logic [XLEN-1:0] jalr_sum_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] next_pc_s;
   logic [XLEN-1:0] link_s;
   logic            bht_wr_en_s;
   logic            unused_lookup_s;

   logic            out_valid_r;
   logic            br_en_r;
   logic            redirect_r;
   logic [XLEN-1:0] redirect_pc_r;
   logic [XLEN-1:0] link_data_r;
   logic            misalign_r;
   logic            illegal_r;

   // Anything presented while a redirect is outstanding is wrong-path.
   assign accept_s = bus.in_valid & ~stall & ~redirect_r;

   // Opcode decode into the resolution kind.
   always_comb begin
      kind_s = KIND_OTHER;
      case (bus.in_opcode)
         OP_BRANCH: kind_s = KIND_BRANCH;
         OP_JAL:    kind_s = KIND_JAL;
         OP_JALR:   kind_s = KIND_JALR;
         default:   kind_s = KIND_OTHER;
      endcase
   end

   // Branch condition evaluation; the two unused funct3 codes are flagged illegal.
   always_comb begin
      cond_s     = 1'b0;
      legal_f3_s = 1'b1;
      case (bus.in_funct3)
         F3_BEQ:  cond_s = (bus.rs1_data == bus.rs2_data);
         F3_BNE:  cond_s = (bus.rs1_data != bus.rs2_data);
         F3_BLT:  cond_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
         F3_BGE:  cond_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         F3_BLTU: cond_s = (bus.rs1_data <  bus.rs2_data);
         F3_BGEU: cond_s = (bus.rs1_data >= bus.rs2_data);
         default: begin
            cond_s     = 1'b0;
            legal_f3_s = 1'b0;
         end
      endcase
   end

   assign pc_plus4_s = bus.in_pc + PC_STEP;
   assign jalr_sum_s = bus.rs1_data + bus.in_imm;

   // Target, outcome and link value per instruction kind; all sums wrap at XLEN.
   always_comb begin
      target_s  = bus.in_pc + bus.in_imm;
      taken_s   = 1'b0;
      illegal_s = 1'b0;
      link_s    = {XLEN{1'b0}};
      case (kind_s)
         KIND_BRANCH: begin
            taken_s   = cond_s & legal_f3_s;
            illegal_s = ~legal_f3_s;
         end
         KIND_JAL: begin
            taken_s = 1'b1;
            link_s  = pc_plus4_s;
         end
         KIND_JALR: begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            taken_s  = 1'b1;
            link_s   = pc_plus4_s;
         end
         default: begin
            target_s = pc_plus4_s;
            taken_s  = 1'b0;
         end
      endcase
   end

   // A misaligned taken target goes to the trap path, so fetch is not redirected.
   always_comb begin
      next_pc_s  = taken_s ? target_s : pc_plus4_s;
      misalign_s = taken_s & target_s[1];
      if (misalign_s | illegal_s) begin
         redirect_s = 1'b0;
      end else begin
         redirect_s = (taken_s != bus.in_pred_taken) |
                      (taken_s & (target_s != bus.in_pred_target));
      end
   end

   // Result stage: reset wins, stall freezes, an empty slot emits a clean bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r   <= 1'b0;
         br_en_r       <= 1'b0;
         redirect_r    <= 1'b0;
         redirect_pc_r <= {XLEN{1'b0}};
         link_data_r   <= {XLEN{1'b0}};
         misalign_r    <= 1'b0;
         illegal_r     <= 1'b0;
      end else if (stall) begin
         out_valid_r   <= out_valid_r;
         br_en_r       <= br_en_r;
         redirect_r    <= redirect_r;
         redirect_pc_r <= redirect_pc_r;
         link_data_r   <= link_data_r;
         misalign_r    <= misalign_r;
         illegal_r     <= illegal_r;
      end else if (accept_s) begin
         out_valid_r   <= 1'b1;
         br_en_r       <= taken_s;
         redirect_r    <= redirect_s;
         redirect_pc_r <= next_pc_s;
         link_data_r   <= link_s;
         misalign_r    <= misalign_s;
         illegal_r     <= illegal_s;
      end else begin
         out_valid_r   <= 1'b0;
         br_en_r       <= 1'b0;
         redirect_r    <= 1'b0;
         redirect_pc_r <= {XLEN{1'b0}};
         link_data_r   <= {XLEN{1'b0}};
         misalign_r    <= 1'b0;
         illegal_r     <= 1'b0;
      end
   end

   assign bus.out_valid   = out_valid_r;
   assign bus.br_en       = br_en_r;
   assign bus.redirect    = redirect_r;
   assign bus.redirect_pc = redirect_pc_r;
   assign bus.link_data   = link_data_r;
   assign bus.misalign    = misalign_r;
   assign bus.illegal     = illegal_r;

   // Only accepted conditional branches with a legal compare train the table.
   assign bht_wr_en_s = accept_s & (kind_s == KIND_BRANCH) & legal_f3_s;

   branch_bht #(
      .IDX_W (BHT_IDX_W),
      .INIT  (BHT_INIT)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bht_wr_en_s),
      .wr_idx   (bus.in_pc[BHT_IDX_W+1:2]),
      .wr_taken (taken_s),
      .rd_idx   (lookup_pc[BHT_IDX_W+1:2]),
      .rd_taken (lookup_taken)
   );

   assign unused_lookup_s = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: each driven instruction pushes its expected
// result, which is popped and compared one clock later.
module tb_branch_unit;

   localparam int XLEN = 32;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_ALU  = 7'b0110011;

   // {out_valid, br_en, redirect, misalign, illegal, redirect_pc, link_data}
   typedef logic [68:0] res_t;
   localparam res_t BUBBLE = 69'd0;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            stall = 1'b0;
   logic [XLEN-1:0] lookup_pc = 32'd0;
   logic            lookup_taken;

   res_t exp_q [$];
   res_t last_exp = BUBBLE;
   res_t got;
   res_t exp;
   int   checks = 0;
   int   errors = 0;

   branch_unit_if #(.XLEN(XLEN)) bus ();

   branch_unit #(.XLEN(XLEN), .BHT_IDX_W(6), .BHT_INIT(2'b01)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .lookup_pc    (lookup_pc),
      .lookup_taken (lookup_taken),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   function automatic res_t pack(input logic ov, input logic br, input logic rd,
                                 input logic ma, input logic il,
                                 input logic [31:0] rpc, input logic [31:0] link);
      return {ov, br, rd, ma, il, rpc, link};
   endfunction

   function automatic res_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic pt, input logic [31:0] ptgt);
      logic tk, il, ma, rd;
      logic [31:0] tgt, link, npc;
      tk = 1'b0; il = 1'b0; link = 32'd0;
      tgt = pc + imm;
      if (op == OPC_BR) begin
         case (f3)
            3'b000: tk = (a == b);
            3'b001: tk = (a != b);
            3'b100: tk = ($signed(a) < $signed(b));
            3'b101: tk = ($signed(a) >= $signed(b));
            3'b110: tk = (a < b);
            3'b111: tk = (a >= b);
            default: il = 1'b1;
         endcase
      end else if (op == OPC_JAL) begin
         tk = 1'b1; link = pc + 32'd4;
      end else if (op == OPC_JALR) begin
         tgt = (a + imm) & 32'hFFFF_FFFE; tk = 1'b1; link = pc + 32'd4;
      end
      npc = tk ? tgt : pc + 32'd4;
      ma = tk & tgt[1];
      rd = !ma && !il && ((tk != pt) || (tk && (tgt != ptgt)));
      return {1'b1, tk, rd, ma, il, npc, link};
   endfunction

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ptgt, input res_t e);
      bus.in_valid = v; bus.in_opcode = op; bus.in_funct3 = f3;
      bus.in_pc = pc; bus.in_imm = imm; bus.rs1_data = a; bus.rs2_data = b;
      bus.in_pred_taken = pt; bus.in_pred_target = ptgt;
      exp_q.push_back(e);
      last_exp = e;
   endtask

   task automatic idle();
      drive(1'b0, OPC_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, BUBBLE);
   endtask

   task automatic advance(output res_t g, output res_t e);
      @(posedge clk);
      #1;
      g = {bus.out_valid, bus.br_en, bus.redirect, bus.misalign, bus.illegal,
           bus.redirect_pc, bus.link_data};
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {69{1'b1}};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         idle();
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL reset_out got=%h exp=%h", got, exp); end
      end
      for (int i = 0; i < 2; i++) begin
         lookup_pc = (i == 0) ? 32'h0 : 32'hFC;
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin errors++; $display("FAIL reset_bht got=%b exp=0", lookup_taken); end
      end
      rst = 1'b0;
   endtask

   task automatic test_beq();
      drive(1'b1, OPC_BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0,
            pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL beq_redirect got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_ALU, 3'b000, 32'h104, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, BUBBLE);
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL squash got=%h exp=%h", got, exp); end
   endtask

   task automatic test_compare();
      drive(1'b1, OPC_BR, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h210,
            pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h210, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL blt_signed got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_BR, 3'b110, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0,
            pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bltu_unsigned got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_BR, 3'b111, 32'h20C, 32'h10, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0,
            pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h210, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bgeu_unsigned got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_BR, 3'b101, 32'h208, 32'h10, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h300,
            pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h218, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bge_wrong_target got=%h exp=%h", got, exp); end
      idle();
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL redirect_pulse got=%h exp=%h", got, exp); end
   endtask

   task automatic test_jumps();
      drive(1'b1, OPC_JALR, 3'b000, 32'h300, 32'd0, 32'h1003, 32'd0, 1'b0, 32'd0,
            pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1002, 32'h304));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jalr_misalign got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_JALR, 3'b000, 32'h304, 32'd0, 32'h1001, 32'd0, 1'b1, 32'h1000,
            pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h308));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jalr_aligned got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_JAL, 3'b000, 32'h400, 32'h40, 32'd0, 32'd0, 1'b1, 32'h440,
            pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h440, 32'h404));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jal_predicted got=%h exp=%h", got, exp); end
      drive(1'b1, OPC_JAL, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 1'b0, 32'd0,
            pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFF4));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jal_wrap got=%h exp=%h", got, exp); end
      idle();
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jal_after got=%h exp=%h", got, exp); end
   endtask

   task automatic test_bht();
      logic exp_lk;
      lookup_pc = 32'h40;
      #1;
      checks++;
      if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_init got=%b exp=0", lookup_taken); end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b1, 32'h48,
               pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 32'd0));
         exp_lk = (k == 0) ? 1'b0 : 1'b1;
         checks++;
         if (lookup_taken !== exp_lk) begin errors++; $display("FAIL bht_same_edge k=%0d got=%b exp=%b", k, lookup_taken, exp_lk); end
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL bne_taken got=%h exp=%h", got, exp); end
         checks++;
         if (lookup_taken !== 1'b1) begin errors++; $display("FAIL bht_taken_train k=%0d got=%b exp=1", k, lookup_taken); end
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd3, 32'd3, 1'b0, 32'd0,
               pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'd0));
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL bne_not_taken got=%h exp=%h", got, exp); end
         exp_lk = (k == 0) ? 1'b1 : 1'b0;
         checks++;
         if (lookup_taken !== exp_lk) begin errors++; $display("FAIL bht_nt_train k=%0d got=%b exp=%b", k, lookup_taken, exp_lk); end
      end
      idle();
      advance(got, exp);
      lookup_pc = 32'h44;
      #1;
      checks++;
      if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_neighbor got=%b exp=0", lookup_taken); end
   endtask

   task automatic test_stall();
      drive(1'b1, OPC_ALU, 3'b000, 32'h500, 32'd0, 32'd0, 32'd0, 1'b1, 32'h900,
            pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h504, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL nonbranch_redirect got=%h exp=%h", got, exp); end
      lookup_pc = 32'h40;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b0, 32'd0, last_exp);
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, got, exp); end
      end
      checks++;
      if (lookup_taken !== 1'b0) begin errors++; $display("FAIL stall_bht_frozen got=%b exp=0", lookup_taken); end
      stall = 1'b0;
      drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b0, 32'd0, BUBBLE);
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_release_squash got=%h exp=%h", got, exp); end
      checks++;
      if (lookup_taken !== 1'b0) begin errors++; $display("FAIL squash_bht_frozen got=%b exp=0", lookup_taken); end
      idle();
      advance(got, exp);
   endtask

   task automatic test_illegal();
      lookup_pc = 32'h80;
      drive(1'b1, OPC_BR, 3'b001, 32'h80, 32'h8, 32'd1, 32'd2, 1'b1, 32'h88,
            pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h88, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL train_80 got=%h exp=%h", got, exp); end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, OPC_BR, (k == 0) ? 3'b010 : 3'b011, 32'h80, 32'h8, 32'd1, 32'd2,
               (k == 0) ? 1'b1 : 1'b0, 32'h88,
               pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h84, 32'd0));
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL illegal_f3 k=%0d got=%h exp=%h", k, got, exp); end
         checks++;
         if (lookup_taken !== 1'b1) begin errors++; $display("FAIL illegal_bht got=%b exp=1", lookup_taken); end
      end
      drive(1'b1, OPC_ALU, 3'b000, 32'h600, 32'h40, 32'd0, 32'd0, 1'b0, 32'd0,
            pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h604, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL nonbranch_quiet got=%h exp=%h", got, exp); end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] pc, imm, a, b, ptgt;
      logic        v, pt;
      res_t        e;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       op = OPC_BR;
            1:       op = OPC_JAL;
            2:       op = OPC_JALR;
            default: op = OPC_ALU;
         endcase
         if ($urandom_range(0, 2) != 0) op = OPC_BR;
         f3  = 3'($urandom_range(0, 7));
         pc  = 32'($urandom_range(0, 16383)) << 2;
         imm = 32'($urandom_range(0, 1023)) << 1;
         if ($urandom_range(0, 1) == 1) imm = -imm;
         a   = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
         b   = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
         pt  = 1'($urandom_range(0, 1));
         ptgt = ($urandom_range(0, 1) == 1) ? pc + imm : 32'($urandom_range(0, 65535)) << 1;
         v   = ($urandom_range(0, 7) != 0);
         if (v && !last_exp[66]) e = model(op, f3, pc, imm, a, b, pt, ptgt);
         else                    e = BUBBLE;
         drive(v, op, f3, pc, imm, a, b, pt, ptgt, e);
         advance(got, exp);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL back_to_back n=%0d got=%h exp=%h", n, got, exp); end
      end
      idle();
      advance(got, exp);
   endtask

   task automatic test_reset_mid();
      lookup_pc = 32'h80;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, OPC_BR, 3'b001, 32'h80, 32'h8, 32'd1, 32'd2, 1'b1, 32'h88,
               pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h88, 32'd0));
         advance(got, exp);
      end
      checks++;
      if (lookup_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_bht got=%b exp=1", lookup_taken); end
      rst = 1'b1;
      stall = 1'b1;
      drive(1'b1, OPC_JAL, 3'b000, 32'h700, 32'h40, 32'd0, 32'd0, 1'b0, 32'd0, BUBBLE);
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL midrst_out got=%h exp=%h", got, exp); end
      rst = 1'b0;
      stall = 1'b0;
      idle();
      for (int i = 0; i < 64; i++) begin
         lookup_pc = 32'(i) << 2;
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin errors++; $display("FAIL midrst_bht idx=%0d got=%b exp=0", i, lookup_taken); end
      end
      advance(got, exp);
      lookup_pc = 32'h80;
      drive(1'b1, OPC_BR, 3'b001, 32'h80, 32'h8, 32'd1, 32'd2, 1'b1, 32'h88,
            pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h88, 32'd0));
      advance(got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL post_reset_out got=%h exp=%h", got, exp); end
      checks++;
      if (lookup_taken !== 1'b1) begin errors++; $display("FAIL init_weak_nt got=%b exp=1", lookup_taken); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_compare();
      test_jumps();
      test_bht();
      test_stall();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Parametrised successor to the single-cycle branch-enable logic. Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR in one registered stage. Computes the target, compares the outcome against the fetch-stage prediction, and issues a redirect on mispredict. Owns a 2-bit-counter branch history table (BHT) that fetch reads and resolution trains. Sits between decode/register-read and the fetch PC mux.

Parameters:
XLEN, 32, datapath and PC width
BHT_IDX_W, 6, log2 of BHT entries (64 entries)
BHT_INIT, 2'b01, counter value loaded at reset (weakly not-taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall  in  1  hold stage: input ignored, outputs and BHT frozen
in_valid  in  1  instruction present this cycle
in_opcode  in  7  RV opcode
in_funct3  in  3  branch compare type
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  sign-extended immediate
rs1_data  in  XLEN  source 1
rs2_data  in  XLEN  source 2
in_pred_taken  in  1  fetch prediction
in_pred_target  in  XLEN  fetch predicted target
lookup_pc  in  XLEN  fetch PC for BHT read
lookup_taken  out  1  combinational: BHT[lookup_pc idx][1]
out_valid  out  1  registered: resolved instruction valid
br_en  out  1  registered: actual taken (branch taken or jump)
redirect  out  1  registered: mispredict, fetch must load redirect_pc
redirect_pc  out  XLEN  registered: correct next PC
link_data  out  XLEN  registered: in_pc+4 for JAL/JALR rd write
misalign  out  1  registered: taken target with bit1 set
illegal  out  1  registered: branch opcode with funct3 010/011

Behaviour:
- Reset: all registered outputs 0, every BHT entry = BHT_INIT. Reset overrides stall.
- Latency: 1 cycle, in_* sampled on rising clk when in_valid & !stall & !redirect.
- Squash: while redirect=1 the input is wrong-path; it is dropped and next out_valid=0. Redirect is therefore a single-cycle pulse per mispredict.
- stall=1: all registers hold, including redirect; BHT not written.
- Decode: JAL 1101111, JALR 1100111, BRANCH 1100011; other opcodes give out_valid=1, br_en=0, redirect only if in_pred_taken=1 (redirect_pc=pc+4).
- Compare: funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011 → illegal=1, not taken, no BHT update.
- Target: BRANCH/JAL pc+imm; JALR (rs1+imm)&~1. XLEN-bit wrap, no overflow detection.
- next_pc = taken ? target : pc+4 (wraps).
- misalign = taken & target[1]; when set, redirect=0 and the trap path owns the PC.
- redirect = valid & !misalign & !illegal & (taken != pred_taken | (taken & target != pred_target)); redirect_pc = next_pc.
- link_data = pc+4 for JAL/JALR, 0 otherwise.
- BHT index = pc[BHT_IDX_W+1:2]. On each accepted valid conditional branch (legal funct3), the counter saturates toward taken (max 11) or not-taken (min 00). Writes occur at the clock edge.
- Read-during-write to the same index: lookup_taken returns the pre-update value.
- JAL/JALR never touch the BHT.

Decomposition:
- Shared package branch_pkg: opcode constants (OP_BRANCH, OP_JAL, OP_JALR) and funct3 constants (F3_BEQ..F3_BGEU). Counter-update function sat_update(cnt, taken).
- One sub-module: branch_bht (counter array, combinational read port, synchronous write port, synchronous reset init). Compare, target and redirect logic stay in branch_unit.

Test Plan:
- BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=0 → next cycle br_en=1, redirect=1, redirect_pc=0x120; following input dropped (out_valid=0).
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken. Both with pred matching the outcome → redirect=0.
- JALR rs1=0x1003, imm=0 → target 0x1002, misalign=1, redirect=0, link_data=pc+4. With rs1=0x1001 → target 0x1000, misalign=0.
- BHT: 3 taken BNEs at pc=0x40 → lookup_pc=0x40 yields lookup_taken 0→1→1. A fourth taken BNE keeps the counter at 11. Two not-taken BNEs → lookup_taken=0. Same-edge lookup sees the old value.
- stall=1 held 3 cycles with redirect=1 → redirect stays 1, BHT unchanged. Mid-stream rst=1 → outputs 0, all entries read weakly not-taken.
- funct3=010 on BRANCH → illegal=1, br_en=0, no BHT change. Non-branch opcode with pred_taken=1 → redirect_pc=pc+4.
